run_length_detector: RTL
========================

// Module: run_length_detector
// PURPOSE
//   Parametrised serial run-length detector: watches a 1-bit stream and flags
//   when the current run of identical bits reaches RUN_LEN. It generalises the
//   fixed "four equal bits" detector. It adds a configurable run length, a
//   runtime polarity mode, an input-valid qualifier, a synchronous clear, and
//   run-count and first-hit outputs.
//   It sits on the serial input path feeding pattern/alarm logic.
// PARAMETERS
//   RUN_LEN  4                         consecutive equal bits needed to flag; legal >= 2
//   CNT_W    $clog2(RUN_LEN+1) (=3)    width of run counter; derived, do not override
// PORTS
//   clk       in   1      clock; all state updates on posedge
//   reset     in   1      asynchronous, active-low reset (0 = reset asserted)
//   clear     in   1      synchronous clear to IDLE; priority over in_valid
//   in_valid  in   1      qualifies in; state only advances when 1
//   in        in   1      serial data bit
//   mode      in   2      00 flag 0-runs and 1-runs; 01 1-runs only; 10 0-runs only; 11 none
//   out       out  1      high while current run >= RUN_LEN and run polarity enabled by mode
//   hit       out  1      one-cycle pulse in first cycle out rises for a given run
//   run_bit   out  1      polarity of current run (0 in IDLE)
//   run_cnt   out  CNT_W  length of current run, saturating at RUN_LEN (0 in IDLE)
// BEHAVIOUR
//   - Reset (reset==0, async): state=IDLE, run_bit=0, run_cnt=0, hit flag=0.
//     out=0 and hit=0 immediately; this also applies mid-run.
//   - States: IDLE (no bit seen since reset/clear), RUN (run_bit/run_cnt valid).
//   - Per posedge, in priority order:
//     - clear=1: state->IDLE, run_cnt=0, run_bit=0, new_r=0.
//     - in_valid=1 in IDLE, or in!=run_bit: state->RUN, run_bit<=in, run_cnt<=1.
//     - in_valid=1, RUN, in==run_bit: run_cnt<=min(run_cnt+1, RUN_LEN);
//       the counter never wraps.
//     - in_valid=0: all state holds; invalid cycles do not break a run.
//   - new_r is a registered flag. It is set for exactly one cycle when a valid
//     update moves run_cnt from RUN_LEN-1 to RUN_LEN. It is cleared on every
//     other edge.
//   - out = (run_cnt==RUN_LEN) & enabled(run_bit, mode). This is combinational
//     from registers and mode.
//   - Latency: out rises in the cycle after the edge sampling the RUN_LEN-th equal bit.
//   - hit = out & new_r. A mode change that raises out on an already-saturated
//     run gives out=1, hit=0.
//   - A bit of opposite polarity drops out the next cycle. run_cnt restarts at 1;
//     a new run needs RUN_LEN fresh bits.
//   - mode changes take effect on out in the same cycle. They never alter
//     run_cnt/run_bit.
//   - clear and in_valid in the same cycle: clear wins and the bit is discarded.
// TESTING
//   1. mode=00, in_valid=1, in=0 x6 -> run_cnt 1,2,3,4,4,4.
//      out=0 for the first 3 bits, then out=1 from the cycle after bit 4.
//      hit=1 only that cycle.
//   2. mode=00, in=1,1,1,0,1,1,1,1 -> run_cnt 1,2,3,1,1,2,3,4.
//      out/hit first go high after bit 8; run_bit=1.
//   3. mode=01, in=0 x5 -> run_cnt saturates at 4, out=0, hit=0.
//      Then set mode=00 with no new bits -> out=1 same cycle, hit=0.
//   4. in_valid pattern 1,0,1,0,1,1 with in=1 on valid cycles -> out rises only
//      after the 4th valid bit; run_cnt holds during gaps.
//   5. Run at run_cnt=3, pulse clear -> run_cnt=0, out=0. Next in=1 -> run_cnt=1.
//      Then, with out=1, drive reset=0 between edges -> out, hit, run_cnt=0 immediately.
//   6. RUN_LEN=8 (CNT_W=4), mode=00, in=1 x7 then 0 then 0 x8 -> out stays 0
//      through the 1-run; out=1, hit=1 after the 8th 0 of the 0-run; run_bit=0.

Source files
------------

// File: rtl/run_length_detector.sv
// run_length_detector: flags when the current run of identical serial bits reaches RUN_LEN
module run_length_detector #(
  parameter  int RUN_LEN = 4,
  localparam int CNT_W   = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in,
  input  logic [1:0]       mode,
  output logic             out,
  output logic             hit,
  output logic             run_bit,
  output logic [CNT_W-1:0] run_cnt
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [CNT_W-1:0] MAX = CNT_W'(RUN_LEN);
  state_t           state_q, state_d;
  logic             run_bit_q, run_bit_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             new_q, new_d;
  logic             restart, en;
  assign restart = state_q == IDLE || in != run_bit_q;
  always_comb begin
    state_d   = state_q;
    run_bit_d = run_bit_q;
    run_cnt_d = run_cnt_q;
    new_d     = 1'b0;
    if (clear) begin
      state_d   = IDLE;
      run_bit_d = 1'b0;
      run_cnt_d = '0;
    end else if (in_valid) begin
      state_d   = RUN;
      run_bit_d = in;
      run_cnt_d = restart ? CNT_W'(1) : (run_cnt_q == MAX ? MAX : run_cnt_q + CNT_W'(1));
      new_d     = !restart && run_cnt_q == MAX - CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      run_bit_q <= 1'b0;
      run_cnt_q <= '0;
      new_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_bit_q <= run_bit_d;
      run_cnt_q <= run_cnt_d;
      new_q     <= new_d;
    end
  end
  // mode bit 0 masks 0-runs, mode bit 1 masks 1-runs
  assign en      = run_bit_q ? ~mode[1] : ~mode[0];
  assign out     = run_cnt_q == MAX && en;
  assign hit     = out && new_q;
  assign run_bit = run_bit_q;
  assign run_cnt = run_cnt_q;
endmodule
